// File: rtl/hack_gate_pkg.sv
// rtl/hack_gate_pkg.sv - shared constants for the and/mux/dmux gate bank
package hack_gate_pkg;

    localparam int   DEFAULT_WIDTH = 1;

    // Select encodings shared by the mux and the dmux
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/hack_gate_slice.sv
// rtl/hack_gate_slice.sv - one-bit and/mux/dmux cell
module hack_gate_slice
    import hack_gate_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    input  logic in_i,
    output logic y_and_o,
    output logic y_mux_o,
    output logic a_out_o,
    output logic b_out_o
);

    // Purely bitwise gates; the unselected dmux leg is forced to 0, never floated
    always_comb begin
        y_and_o = a_i & b_i;
        y_mux_o = (sel_i == SEL_B) ? b_i : a_i;
        a_out_o = (sel_i == SEL_A) ? in_i : 1'b0;
        b_out_o = (sel_i == SEL_B) ? in_i : 1'b0;
    end

endmodule

// File: rtl/hack_gate_bank.sv
// rtl/hack_gate_bank.sv - WIDTH-bit and/mux/dmux bank with registered copies
module hack_gate_bank
    import hack_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_mux,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] y_and_q,
    output logic [WIDTH-1:0] y_mux_q,
    output logic [WIDTH-1:0] a_out_q,
    output logic [WIDTH-1:0] b_out_q
);

    logic [WIDTH-1:0] y_and_d;
    logic [WIDTH-1:0] y_mux_d;
    logic [WIDTH-1:0] a_out_d;
    logic [WIDTH-1:0] b_out_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        hack_gate_slice u_slice (
            .a_i     (a[i]),
            .b_i     (b[i]),
            .sel_i   (sel),
            .in_i    (in[i]),
            .y_and_o (y_and[i]),
            .y_mux_o (y_mux[i]),
            .a_out_o (a_out[i]),
            .b_out_o (b_out[i])
        );
    end

    // Next state: capture the combinational outputs when enabled, otherwise hold
    always_comb begin
        y_and_d = y_and_q;
        y_mux_d = y_mux_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        if (en) begin
            y_and_d = y_and;
            y_mux_d = y_mux;
            a_out_d = a_out;
            b_out_d = b_out;
        end
    end

    // Output registers; reset wins over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_and_q <= '0;
            y_mux_q <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            y_and_q <= y_and_d;
            y_mux_q <= y_mux_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
        end
    end

endmodule

// File: tb/tb_hack_gate_bank.sv
// tb/tb_hack_gate_bank.sv - self-checking bench for hack_gate_bank at WIDTH 1 and 16
module tb_hack_gate_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        en;
    logic [0:0]  a1, b1, in1;
    logic [15:0] a16, b16, in16;

    logic [0:0]  y_and1, y_mux1, a_out1, b_out1, y_and_q1, y_mux_q1, a_out_q1, b_out_q1;
    logic [15:0] y_and16, y_mux16, a_out16, b_out16, y_and_q16, y_mux_q16, a_out_q16, b_out_q16;

    // Model of registered outputs: index 0=and 1=mux 2=a_out 3=b_out
    logic [15:0] m1 [4];
    logic [15:0] m16 [4];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hack_gate_bank #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel), .in(in1), .en(en),
        .y_and(y_and1), .y_mux(y_mux1), .a_out(a_out1), .b_out(b_out1),
        .y_and_q(y_and_q1), .y_mux_q(y_mux_q1), .a_out_q(a_out_q1), .b_out_q(b_out_q1)
    );

    hack_gate_bank #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .sel(sel), .in(in16), .en(en),
        .y_and(y_and16), .y_mux(y_mux16), .a_out(a_out16), .b_out(b_out16),
        .y_and_q(y_and_q16), .y_mux_q(y_mux_q16), .a_out_q(a_out_q16), .b_out_q(b_out_q16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference behaviour straight from the truth tables
    function automatic logic [15:0] ref_out(input int k, input logic [15:0] a, input logic [15:0] b,
                                            input logic s, input logic [15:0] d);
        case (k)
            0:       return a & b;
            1:       return s ? b : a;
            2:       return s ? 16'h0 : d;
            default: return s ? d : 16'h0;
        endcase
    endfunction

    task automatic check_comb(input string tag);
        #1;
        check({tag, " y_and1"},  {63'b0, y_and1},  {48'b0, ref_out(0, {15'b0, a1}, {15'b0, b1}, sel, {15'b0, in1})});
        check({tag, " y_mux1"},  {63'b0, y_mux1},  {48'b0, ref_out(1, {15'b0, a1}, {15'b0, b1}, sel, {15'b0, in1})});
        check({tag, " a_out1"},  {63'b0, a_out1},  {48'b0, ref_out(2, {15'b0, a1}, {15'b0, b1}, sel, {15'b0, in1})});
        check({tag, " b_out1"},  {63'b0, b_out1},  {48'b0, ref_out(3, {15'b0, a1}, {15'b0, b1}, sel, {15'b0, in1})});
        check({tag, " y_and16"}, {48'b0, y_and16}, {48'b0, ref_out(0, a16, b16, sel, in16)});
        check({tag, " y_mux16"}, {48'b0, y_mux16}, {48'b0, ref_out(1, a16, b16, sel, in16)});
        check({tag, " a_out16"}, {48'b0, a_out16}, {48'b0, ref_out(2, a16, b16, sel, in16)});
        check({tag, " b_out16"}, {48'b0, b_out16}, {48'b0, ref_out(3, a16, b16, sel, in16)});
    endtask

    task automatic check_regs(input string tag);
        check({tag, " y_and_q1"},  {63'b0, y_and_q1},  {48'b0, m1[0]});
        check({tag, " y_mux_q1"},  {63'b0, y_mux_q1},  {48'b0, m1[1]});
        check({tag, " a_out_q1"},  {63'b0, a_out_q1},  {48'b0, m1[2]});
        check({tag, " b_out_q1"},  {63'b0, b_out_q1},  {48'b0, m1[3]});
        check({tag, " y_and_q16"}, {48'b0, y_and_q16}, {48'b0, m16[0]});
        check({tag, " y_mux_q16"}, {48'b0, y_mux_q16}, {48'b0, m16[1]});
        check({tag, " a_out_q16"}, {48'b0, a_out_q16}, {48'b0, m16[2]});
        check({tag, " b_out_q16"}, {48'b0, b_out_q16}, {48'b0, m16[3]});
    endtask

    // Advance the model by one edge, then step the clock and settle
    task automatic tick();
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                m1[k]  = 16'h0;
                m16[k] = 16'h0;
            end else if (en) begin
                m1[k]  = ref_out(k, {15'b0, a1}, {15'b0, b1}, sel, {15'b0, in1});
                m16[k] = ref_out(k, a16, b16, sel, in16);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m1[k]  = 16'hxxxx;
            m16[k] = 16'hxxxx;
        end
        rst_n = 1'b0; en = 1'b0; sel = 1'b0;
        a1 = 1'b1; b1 = 1'b1; in1 = 1'b1;
        a16 = 16'h1234; b16 = 16'hFF00; in16 = 16'hBEEF;

        // Combinational paths are live during reset
        check_comb("during_reset");
        tick();
        check_regs("after_reset");

        // AND/MUX over all (a,b,sel)
        for (int i = 0; i < 8; i++) begin
            {a1, b1, sel} = 3'(i);
            check_comb($sformatf("and_mux_%0d", i));
        end
        a1 = 1'b1; b1 = 1'b0; sel = 1'b1;
        #1 check("mux_a1_b0_s1", {63'b0, y_mux1}, 64'd0);

        // DMUX over all (sel,in)
        for (int i = 0; i < 4; i++) begin
            {sel, in1} = 2'(i);
            check_comb($sformatf("dmux_%0d", i));
        end
        sel = 1'b1; in1 = 1'b1;
        #1 check("dmux_s1_in1_a_out", {63'b0, a_out1}, 64'd0);
        check("dmux_s1_in1_b_out", {63'b0, b_out1}, 64'd1);

        // Wide directed vector
        a16 = 16'hF0F0; b16 = 16'h3C3C; sel = 1'b1; in16 = 16'hA5A5;
        #1;
        check("w16_and",   {48'b0, y_and16}, 64'h3030);
        check("w16_mux",   {48'b0, y_mux16}, 64'h3C3C);
        check("w16_a_out", {48'b0, a_out16}, 64'h0);
        check("w16_b_out", {48'b0, b_out16}, 64'hA5A5);

        // Reset beats enable, then first enabled edge loads
        rst_n = 1'b0; en = 1'b1;
        tick();
        check_regs("rst_over_en");
        check("rst_over_en_and_q1", {63'b0, y_and_q1}, 64'd0);
        rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1;
        tick();
        check("first_load_and_q1", {63'b0, y_and_q1}, 64'd1);
        check_regs("first_load");

        // Hold with en=0 while combinational outputs track
        a16 = 16'h00FF; b16 = 16'hFF00; sel = 1'b0; in16 = 16'h5A5A;
        tick();
        check("load_mux_q16", {48'b0, y_mux_q16}, 64'h00FF);
        en = 1'b0; a16 = 16'h1111; b16 = 16'h2222; sel = 1'b1; in16 = 16'h3333;
        check_comb("hold_track");
        check("hold_track_mux16", {48'b0, y_mux16}, 64'h2222);
        tick();
        check("hold_mux_q16", {48'b0, y_mux_q16}, 64'h00FF);
        check_regs("hold");

        // Randomized traffic, including occasional mid-operation resets
        for (int n = 0; n < 300; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); in1 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); in16 = 16'($urandom);
            sel = 1'($urandom);
            en = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 15) != 0);
            check_comb($sformatf("rand_comb_%0d", n));
            tick();
            check_regs($sformatf("rand_regs_%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
